wb_mem_arb: RTL and testbench

WB_MEM_ARB -- requirements
Module: wb_mem_arb

---
 rtl/wb_mem_arb.sv | 142 ++++++++++++++
 tb/tb_wb_mem_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arb.sv
// Two-master Wishbone arbiter sharing one memory port, with one idle cycle between grants.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe watchdog; otherwise the err outputs are tied low.
module wb_mem_arb #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic          m0_we_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic          m1_we_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic          s_ack_i,
  input  logic [31:0]   s_dat_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last;
  logic   gnt0;
  logic   gnt1;
  logic   stb_raw;
  logic   tmo;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  // On a tie the master not recorded in last wins; last tracks every grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (last) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= GNT1;
              last  <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: if (!m0_cyc_i) state <= IDLE;
        GNT1: if (!m1_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = '0;
    s_dat_o = 32'h0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_cyc_i & m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_cyc_i & m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A timed-out strobe is withheld from the slave for the error cycle.
  assign s_stb_o  = stb_raw & ~tmo;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [CW-1:0] wd_cnt;

  // An ack in the same cycle as the limit wins, so the limit check excludes s_ack_i.
  assign tmo = stb_raw & ~s_ack_i & (wd_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE || s_ack_i || tmo) begin
      wd_cnt <= '0;
    end else if (s_stb_o) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign m0_err_o = gnt0 & tmo;
  assign m1_err_o = gnt1 & tmo;
`else
  assign tmo      = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arb.sv
// Testbench for wb_mem_arb: table-driven arbitration vectors plus scoreboarded memory transfers.
module tb_wb_mem_arb;

  localparam int AW      = 10;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic       c0, s0, c1, s1, ack;
    logic [1:0] src;
    logic       e_cyc, e_stb, e_ack0, e_ack1;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_adr [2];
  logic [31:0]     m_dat [2];
  logic [3:0]      m_sel [2];
  logic            m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0]     m0_rdat, m1_rdat;
  logic [1:0]      m_ack, m_err;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [31:0]     s_dat;
  logic [3:0]      s_sel;
  logic            s_ack;
  logic [31:0]     s_rdat;

  logic            use_mem, tb_ack;
  logic [31:0]     tb_dat;
  logic            mem_ack;
  logic [31:0]     mem_rd;
  logic [31:0]     mem [32];
  logic [31:0]     shadow [32];
  logic [31:0]     exp_q [$];
  logic            watch;
  int              lock_viol;
  int              errors = 0;
  int              checks = 0;
  vec_t            vecs [14];

  assign m_ack  = {m1_ack, m0_ack};
  assign m_err  = {m1_err, m0_err};
  assign s_ack  = use_mem ? mem_ack : tb_ack;
  assign s_rdat = use_mem ? mem_rd  : tb_dat;

  always #5 clk = ~clk;

  wb_mem_arb #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_adr_i(m_adr[0]), .m0_we_i(m_we[0]),
    .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_adr_i(m_adr[1]), .m1_we_i(m_we[1]),
    .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_sel_o(s_sel), .s_ack_i(s_ack), .s_dat_i(s_rdat)
  );

  // Memory slave: acks one cycle after each new strobe, honours byte selects.
  always @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0;
    end else begin
      mem_ack <= use_mem & s_stb & ~mem_ack;
      if (use_mem && s_stb && !mem_ack) begin
        if (s_we)
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[4:0]][8*b +: 8] <= s_dat[8*b +: 8];
        mem_rd <= mem[s_adr[4:0]];
      end
    end
  end

  always @(negedge clk) begin
    if (rst) lock_viol <= 0;
    else if (watch && m_ack[0]) lock_viol <= lock_viol + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] src, input logic [3:0] e);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack} = in;
    v.src = src;
    {v.e_cyc, v.e_stb, v.e_ack0, v.e_ack1} = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    m_cyc  = {v.c1, v.c0};
    m_stb  = {v.s1, v.s0};
    tb_ack = v.ack;
    tb_dat = 32'hA500_0000 + idx;
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    logic [3:0] e_sel;
    logic       e_we;
    e_sel = (v.src == 2'd1) ? 4'h3 : (v.src == 2'd2) ? 4'hC : 4'h0;
    e_we  = (v.src == 2'd1);
    checkOutput($sformatf("v%0d_s_cyc", idx), s_cyc, v.e_cyc);
    checkOutput($sformatf("v%0d_s_stb", idx), s_stb, v.e_stb);
    checkOutput($sformatf("v%0d_s_sel", idx), s_sel, e_sel);
    checkOutput($sformatf("v%0d_s_we", idx), s_we, e_we);
    if (v.src != 2'd0) begin
      checkOutput($sformatf("v%0d_s_adr", idx), s_adr, (v.src == 2'd1) ? 32'h011 : 32'h022);
      checkOutput($sformatf("v%0d_s_dat", idx), s_dat, (v.src == 2'd1) ? 32'h1111_0000 : 32'h2222_0000);
    end
    checkOutput($sformatf("v%0d_m0_ack", idx), m0_ack, v.e_ack0);
    checkOutput($sformatf("v%0d_m1_ack", idx), m1_ack, v.e_ack1);
    checkOutput($sformatf("v%0d_m0_dat", idx), m0_rdat, 32'hA500_0000 + idx);
    checkOutput($sformatf("v%0d_m1_dat", idx), m1_rdat, 32'hA500_0000 + idx);
    checkOutput($sformatf("v%0d_err", idx), m_err, 0);
  endtask

  // One strobed access by master m; the read expectation is queued when the request is driven.
  task automatic doAccess(input int m, input logic we, input logic [AW-1:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic keep);
    logic        got;
    logic [31:0] act, exp;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat[m] = dat;  m_sel[m] = sel;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) shadow[adr[4:0]][8*b +: 8] = dat[8*b +: 8];
    end else begin
      exp_q.push_back(shadow[adr[4:0]]);
    end
    got = 1'b0;
    act = 32'h0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (m_ack[m] === 1'b1) begin
        got = 1'b1;
        act = (m == 0) ? m0_rdat : m1_rdat;
      end
    end
    checkOutput($sformatf("m%0d_ack_seen", m), got, 1);
    if (!we) begin
      exp = exp_q.pop_front();
      if (got) checkOutput($sformatf("m%0d_rd_data", m), act, exp);
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    if (!keep) m_cyc[m] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("m%0d_ack_pulse", m), m_ack[m], 0);
  endtask

  task automatic idleWait();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(5'b11111, 2'd0, 4'b0000);
    vecs[1]  = mk(5'b11110, 2'd1, 4'b1100);
    vecs[2]  = mk(5'b11111, 2'd1, 4'b1110);
    vecs[3]  = mk(5'b10110, 2'd1, 4'b1000);
    vecs[4]  = mk(5'b00110, 2'd1, 4'b0000);
    vecs[5]  = mk(5'b00111, 2'd0, 4'b0000);
    vecs[6]  = mk(5'b11111, 2'd2, 4'b1101);
    vecs[7]  = mk(5'b11000, 2'd2, 4'b0000);
    vecs[8]  = mk(5'b11110, 2'd0, 4'b0000);
    vecs[9]  = mk(5'b00110, 2'd1, 4'b0000);
    vecs[10] = mk(5'b00110, 2'd0, 4'b0000);
    vecs[11] = mk(5'b00110, 2'd2, 4'b1100);
    vecs[12] = mk(5'b00001, 2'd2, 4'b0001);
    vecs[13] = mk(5'b00000, 2'd0, 4'b0000);

    m_cyc = 2'b00; m_stb = 2'b00;
    m_we  = 2'b01;
    m_adr[0] = 10'h011; m_dat[0] = 32'h1111_0000; m_sel[0] = 4'h3;
    m_adr[1] = 10'h022; m_dat[1] = 32'h2222_0000; m_sel[1] = 4'hC;
    use_mem = 1'b0; tb_ack = 1'b0; tb_dat = 32'h0; watch = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_s_cyc", s_cyc, 0);
    checkOutput("rst_s_stb", s_stb, 0);
    checkOutput("rst_s_sel", s_sel, 0);
    checkOutput("rst_acks", m_ack, 0);
    checkOutput("rst_errs", m_err, 0);

    // Arbitration walk: IDLE ack ignored, first tie to m0, locking, idle gap, alternation.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i], i);
      @(negedge clk);
      checkVector(vecs[i], i);
    end

    // Single master write then read-back through the shared memory.
    idleWait();
    use_mem = 1'b1; tb_ack = 1'b0;
    doAccess(0, 1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
    doAccess(0, 1'b0, 10'd5, 32'h0, 4'hF, 1'b0);

    // m1 holds the bus across three accesses while m0 waits.
    idleWait();
    m_cyc[1] = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 10'd5; m_sel[0] = 4'hF;
    watch = 1'b1;
    doAccess(1, 1'b1, 10'd5, 32'h0000_CAFE, 4'h3, 1'b1);
    doAccess(1, 1'b0, 10'd5, 32'h0, 4'hF, 1'b1);
    doAccess(1, 1'b0, 10'd5, 32'h0, 4'hF, 1'b0);
    checkOutput("lock_fall_cyc", s_cyc, 0);
    @(negedge clk);
    checkOutput("lock_gap_cyc", s_cyc, 0);
    checkOutput("lock_gap_sel", s_sel, 0);
    @(negedge clk);
    checkOutput("lock_m0_gnt_cyc", s_cyc, 1);
    checkOutput("lock_m0_gnt_adr", s_adr, 5);
    checkOutput("lock_m0_gnt_sel", s_sel, 4'hF);
    @(posedge clk); #1;
    watch = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    checkOutput("lock_m0_ack", lock_viol, 0);

    // Stalled slave: watchdog behaviour depends on the build.
    idleWait();
    idleWait();
    use_mem = 1'b0; tb_ack = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      logic e_err;
`ifdef WB_ARB_TIMEOUT_EN
      e_err = (i == TIMEOUT + 1);
`else
      e_err = 1'b0;
`endif
      @(negedge clk);
      checkOutput($sformatf("wd%0d_m0_err", i), m0_err, e_err);
      checkOutput($sformatf("wd%0d_s_stb", i), s_stb, !e_err);
      checkOutput($sformatf("wd%0d_m1_err", i), m1_err, 0);
    end
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;

    // Reset while m1 is mid-transfer.
    idleWait();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstx_pre_cyc", s_cyc, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tb_ack = 1'b1;
    @(negedge clk);
    checkOutput("rstx_s_cyc", s_cyc, 0);
    checkOutput("rstx_s_stb", s_stb, 0);
    checkOutput("rstx_m1_ack", m1_ack, 0);
    checkOutput("rstx_m1_err", m1_err, 0);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; tb_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstx_after_cyc", s_cyc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
